inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- 2-wide fetch engine and write side of the instruction buffer.
- Issues one 64-bit aligned instruction-memory load at a time and splits the returned line into two instruction slots.
- Presents the pair to the buffer as a one-cycle `if_ib_packet[0:1]` push.
- Flow control is credit-based against buffer depth; squash redirects the PC.

Parameters:
- CREDITS, 16, instruction-buffer depth in pair entries; must equal the buffer's DEPTH.
- RESET_PC, 32'h0, PC loaded at reset; must be 4-byte aligned.
- CW, $clog2(CREDITS)+1, credit counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- squash  in  1  redirect pulse; same cycle as the buffer's squash.
- squash_pc  in  32  redirect target, 4-byte aligned.
- pair_pop  in  1  one-cycle pulse when the buffer retires a pair entry (second slot read).
- Imem2proc_response  in  4  nonzero = request accepted, value is its tag.
- Imem2proc_data  in  64  returned line.
- Imem2proc_tag  in  4  tag of the data returning this cycle; 0 = none.
- proc2Imem_command  out  2  BUS_NONE=0, BUS_LOAD=1.
- proc2Imem_addr  out  32  {pc[31:3],3'b0}.
- if_ib_packet[0:1]  out  IF_IB_PACKET x2  fields valid, inst, PC, NPC; slot 0 = low word.
- credits  out  CW  free buffer entries, debug/verification visibility.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, pc=RESET_PC, credits=CREDITS, drop=0, saved_tag=0.
  - Both packet slots all-zero; proc2Imem_command=BUS_NONE; proc2Imem_addr=0.
- FSM IDLE:
  - Go to REQ when credits>0, else stay.
  - Command is BUS_NONE.
- FSM REQ:
  - Drives BUS_LOAD and addr={pc[31:3],3'b0}.
  - If Imem2proc_response!=0: latch saved_tag, decrement credits, go to WAIT.
  - Otherwise hold the request unchanged.
- FSM WAIT:
  - Command is BUS_NONE.
  - Data is consumed when Imem2proc_tag==saved_tag and saved_tag!=0.
  - If drop==0, the next cycle drives a push (valid for exactly one cycle):
    - slot0: valid=~pc[2], inst=data[31:0], PC={pc[31:3],3'b000}, NPC=PC+4.
    - slot1: valid=1, inst=data[63:32], PC={pc[31:3],3'b100}, NPC=PC+4.
    - pc becomes {pc[31:3],3'b0}+8.
  - If drop==1: no push, no credit refund, pc unchanged, drop cleared.
  - After consuming data, go to REQ if credits>0 (post-update), else IDLE.
- Push latency is one cycle after the matching tag.
  - Packet valid outputs are registered.
  - Both slots' valid are 0 in all non-push cycles.
- Back-to-back operation: a new request may be issued in the same cycle the previous push is presented.
- Credits:
  - pair_pop increments credits.
  - Acceptance in REQ decrements credits.
  - Both in the same cycle leave credits unchanged.
  - credits never exceeds CREDITS; a pop at CREDITS is ignored and flagged by an assertion.
  - credits never underflows, since no request is issued at 0.
- Squash (priority over all other events):
  - pc=squash_pc, credits=CREDITS, pair_pop ignored.
  - The push that would occur this cycle is suppressed (valid=0).
  - Command is forced to BUS_NONE this cycle.
  - From REQ or IDLE: state goes to REQ.
  - From WAIT with data not yet returned: drop=1, stay in WAIT.
  - From WAIT with data returning this same cycle: the data is discarded, drop stays 0, go to REQ.
- Squash to a target with squash_pc[2]=1: the next push has slot0 valid=0 and slot1 valid=1.
- Reset mid-transaction: outstanding memory tags are abandoned; a stale tag returning after reset is ignored because saved_tag=0.
- PC arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Reset/first fetch: release reset with RESET_PC=0; accept with tag 3; return tag 3 with data 64'hBBBB_BBBB_AAAA_AAAA.
  - Required: one-cycle push, slot0 {1, AAAAAAAA, PC 0, NPC 4}, slot1 {1, BBBBBBBB, PC 4, NPC 8}.
  - Required: next proc2Imem_addr=8, credits=15.
- Unaligned redirect: squash with squash_pc=0x104.
  - Required: next addr=0x100.
  - Required: push with slot0.valid=0 and slot1 {PC 0x104, NPC 0x108}; then addr=0x108.
- Credit exhaustion: never pulse pair_pop.
  - Required: exactly 16 accepted requests, credits=0, FSM idles with command BUS_NONE.
  - Required: one pair_pop gives exactly one more BUS_LOAD.
- Squash during WAIT: squash to 0x200 while tag 5 is outstanding, then return tag 5.
  - Required: no push, credits=16 after the squash.
  - Required: next request addr=0x200.
- Simultaneous events: pair_pop in the same cycle as an acceptance at credits=8.
  - Required: credits stays 8.
  - Required: with squash also high, credits=16 and command=BUS_NONE that cycle.
- Reset mid-operation: assert reset while in WAIT with tag 7 outstanding, then return tag 7.
  - Required: no push, state IDLE→REQ, addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Two-wide instruction fetch: keeps one aligned 64-bit load in flight and splits
// each returned line into a two-slot push toward the instruction buffer.
module inst_fetch_unit #(
  parameter int          CREDITS  = 16,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CW       = $clog2(CREDITS) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  input  logic [31:0]   squash_pc,
  input  logic          pair_pop,
  input  logic [3:0]    Imem2proc_response,
  input  logic [63:0]   Imem2proc_data,
  input  logic [3:0]    Imem2proc_tag,
  output logic [1:0]    proc2Imem_command,
  output logic [31:0]   proc2Imem_addr,
  output logic [96:0]   if_ib_packet [0:1],
  output logic [CW-1:0] credits,
  output logic [1:0]    fsm_state
);

  // Packet slot layout, MSB first: {valid, inst[31:0], PC[31:0], NPC[31:0]}.
  // fsm_state encoding: 0 = IDLE, 1 = REQ, 2 = WAIT.
  //
  // Memory handshake: a request is offered while proc2Imem_command == BUS_LOAD
  // and is accepted in the cycle Imem2proc_response is nonzero (that value is
  // its tag); the offer holds unchanged until accepted. The line is returned in
  // the cycle Imem2proc_tag equals the accepted tag. The buffer side has no
  // ready: a push is only issued against a held credit, and pair_pop returns one.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0]    BUS_NONE    = 2'd0;
  localparam logic [1:0]    BUS_LOAD    = 2'd1;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE         = CW'(1);

  state_t        state_q, state_d;
  logic [31:2]   pc_q, pc_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          drop_q, drop_d;
  logic [3:0]    tag_q, tag_d;
  logic [96:0]   slot0_q, slot0_d;
  logic [96:0]   slot1_q, slot1_d;

  logic [31:0]   line_pc;
  logic [31:0]   next_line;
  logic          cmd_load;
  logic          accept;
  logic          consume;
  logic          unused_squash_pc_bits;

  // Targets are word aligned, so the byte-offset bits carry nothing.
  assign unused_squash_pc_bits = ^squash_pc[1:0];

  assign line_pc   = {pc_q[31:3], 3'b000};
  assign next_line = line_pc + 32'd8;
  assign cmd_load  = (state_q == REQ) && !squash;
  assign accept    = cmd_load && (Imem2proc_response != 4'd0);
  assign consume   = (state_q == WAIT) && (tag_q != 4'd0) && (Imem2proc_tag == tag_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    credits_d = credits_q;
    drop_d    = drop_q;
    tag_d     = tag_q;
    slot0_d   = '0;
    slot1_d   = '0;

    if (accept && !pair_pop) begin
      credits_d = credits_q - ONE;
    end else if (pair_pop && !accept && (credits_q != CREDITS_MAX)) begin
      credits_d = credits_q + ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (credits_q != '0) state_d = REQ;
      end
      REQ: begin
        if (accept) begin
          tag_d   = Imem2proc_response;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (consume) begin
          // A line fetched before a redirect is swallowed without a push.
          if (!drop_q) begin
            slot0_d = {~pc_q[2], Imem2proc_data[31:0], line_pc, line_pc + 32'd4};
            slot1_d = {1'b1, Imem2proc_data[63:32], line_pc | 32'd4, next_line};
            pc_d    = next_line[31:2];
          end
          drop_d  = 1'b0;
          state_d = (credits_d != '0) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over everything: the buffer is flushed in the same cycle.
    if (squash) begin
      pc_d      = squash_pc[31:2];
      credits_d = CREDITS_MAX;
      slot0_d   = '0;
      slot1_d   = '0;
      if ((state_q == WAIT) && !consume) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC[31:2];
      credits_q <= CREDITS_MAX;
      drop_q    <= 1'b0;
      tag_q     <= 4'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      credits_q <= credits_d;
      drop_q    <= drop_d;
      tag_q     <= tag_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
    end
  end

  assign proc2Imem_command = cmd_load ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = cmd_load ? line_pc : 32'd0;
  // The buffer squashes in the same cycle, so a push already on the wires is cancelled.
  assign if_ib_packet[0]   = {slot0_q[96] & ~squash, slot0_q[95:0]};
  assign if_ib_packet[1]   = {slot1_q[96] & ~squash, slot1_q[95:0]};
  assign credits           = credits_q;
  assign fsm_state         = state_q;

  pop_at_full_a: assert property (@(posedge clock) disable iff (!reset)
    !(pair_pop && !squash && !accept && (credits_q == CREDITS_MAX)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed redirect table, multi-cycle corner sequences
// and a randomized run against a transaction-level fetch model.
module tb_inst_fetch_unit;

  localparam int         CREDITS  = 16;
  localparam int         CW       = $clog2(CREDITS) + 1;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic [31:0]   squash_pc;
  logic          pair_pop;
  logic [3:0]    resp;
  logic [63:0]   mdata;
  logic [3:0]    mtag;
  logic [1:0]    cmd;
  logic [31:0]   addr;
  logic [96:0]   pkt [0:1];
  logic [CW-1:0] credits;
  logic [1:0]    fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] target;
    logic [63:0] data;
    logic [31:0] exp_addr;
    logic [96:0] exp_s0;
    logic [96:0] exp_s1;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t vecs [5];
  logic [193:0] exp_q [$];

  inst_fetch_unit #(.CREDITS(CREDITS), .RESET_PC(32'h0)) dut (
    .clock              (clock),
    .reset              (reset),
    .squash             (squash),
    .squash_pc          (squash_pc),
    .pair_pop           (pair_pop),
    .Imem2proc_response (resp),
    .Imem2proc_data     (mdata),
    .Imem2proc_tag      (mtag),
    .proc2Imem_command  (cmd),
    .proc2Imem_addr     (addr),
    .if_ib_packet       (pkt),
    .credits            (credits),
    .fsm_state          (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    squash    = 1'b0;
    squash_pc = 32'd0;
    pair_pop  = 1'b0;
    resp      = 4'd0;
    mtag      = 4'd0;
    mdata     = 64'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [193:0] pair_of(input logic [31:0] pc, input logic [63:0] d);
    logic [31:0] base;
    base = {pc[31:3], 3'b000};
    return {~pc[2], d[31:0], base, base + 32'd4, 1'b1, d[63:32], base + 32'd4, base + 32'd8};
  endfunction

  // ---------------- driver tasks ----------------
  // Memory that accepts every offered request at once and returns it next cycle.
  task automatic auto_serve(input int cycles, input int max_acc, output int acc, output int push);
    logic [3:0] pend;
    pend = 4'd0;
    acc  = 0;
    push = 0;
    for (int c = 0; c < cycles; c++) begin
      mtag  = pend;
      mdata = {32'hB000_0000 + 32'(c), 32'hA000_0000 + 32'(c)};
      resp  = 4'd0;
      pend  = 4'd0;
      #1;
      if (pkt[1][96]) push++;
      if (cmd == BUS_LOAD && acc < max_acc) begin
        resp = 4'((acc % 15) + 1);
        pend = resp;
        acc++;
      end
      tick();
    end
    resp = 4'd0;
    mtag = 4'd0;
  endtask

  // ---------------- test body ----------------
  initial begin
    int acc, push;

    vecs[0] = '{32'h0000_0104, 64'h1111_2222_3333_4444, 32'h0000_0100,
                {1'b0, 32'h3333_4444, 32'h0000_0100, 32'h0000_0104},
                {1'b1, 32'h1111_2222, 32'h0000_0104, 32'h0000_0108}, 32'h0000_0108};
    vecs[1] = '{32'h0000_0200, 64'hDEAD_BEEF_CAFE_F00D, 32'h0000_0200,
                {1'b1, 32'hCAFE_F00D, 32'h0000_0200, 32'h0000_0204},
                {1'b1, 32'hDEAD_BEEF, 32'h0000_0204, 32'h0000_0208}, 32'h0000_0208};
    vecs[2] = '{32'hFFFF_FFF8, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFF8,
                {1'b1, 32'h89AB_CDEF, 32'hFFFF_FFF8, 32'hFFFF_FFFC},
                {1'b1, 32'h0123_4567, 32'hFFFF_FFFC, 32'h0000_0000}, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFC, 64'h5555_6666_7777_8888, 32'hFFFF_FFF8,
                {1'b0, 32'h7777_8888, 32'hFFFF_FFF8, 32'hFFFF_FFFC},
                {1'b1, 32'h5555_6666, 32'hFFFF_FFFC, 32'h0000_0000}, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000, 64'hFEDC_BA98_7654_3210, 32'h8000_0000,
                {1'b1, 32'h7654_3210, 32'h8000_0000, 32'h8000_0004},
                {1'b1, 32'hFEDC_BA98, 32'h8000_0004, 32'h8000_0008}, 32'h8000_0008};

    // Reset state and first fetch
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst_cmd", 256'(cmd), 256'(BUS_NONE));
    check("rst_addr", 256'(addr), 256'(0));
    check("rst_credits", 256'(credits), 256'(16));
    check("rst_pkt0", 256'(pkt[0]), 256'(0));
    check("rst_pkt1", 256'(pkt[1]), 256'(0));
    check("rst_state", 256'(fsm_state), 256'(ST_IDLE));
    reset = 1'b1;
    tick();
    check("first_state", 256'(fsm_state), 256'(ST_REQ));
    check("first_cmd", 256'(cmd), 256'(BUS_LOAD));
    check("first_addr", 256'(addr), 256'(0));
    resp = 4'd3;
    tick();
    resp = 4'd0;
    #1;
    check("first_credits", 256'(credits), 256'(15));
    check("first_wait_cmd", 256'(cmd), 256'(BUS_NONE));
    mtag  = 4'd3;
    mdata = 64'hBBBB_BBBB_AAAA_AAAA;
    tick();
    mtag  = 4'd0;
    mdata = 64'd0;
    #1;
    check("first_slot0", 256'(pkt[0]), 256'({1'b1, 32'hAAAA_AAAA, 32'h0, 32'h4}));
    check("first_slot1", 256'(pkt[1]), 256'({1'b1, 32'hBBBB_BBBB, 32'h4, 32'h8}));
    check("first_next_addr", 256'(addr), 256'(8));
    check("first_next_cmd", 256'(cmd), 256'(BUS_LOAD));
    tick();
    check("first_push_once", 256'({pkt[0][96], pkt[1][96]}), 256'(0));

    // Redirect table: squash while a request is offered, then fetch the target line
    for (int i = 0; i < 5; i++) begin
      do_reset();
      tick();
      resp      = 4'd9;
      squash    = 1'b1;
      squash_pc = vecs[i].target;
      #1;
      check($sformatf("vec%0d_squash_cmd", i), 256'(cmd), 256'(BUS_NONE));
      tick();
      squash = 1'b0;
      resp   = 4'd0;
      #1;
      check($sformatf("vec%0d_credits", i), 256'(credits), 256'(16));
      check($sformatf("vec%0d_cmd", i), 256'(cmd), 256'(BUS_LOAD));
      check($sformatf("vec%0d_addr", i), 256'(addr), 256'(vecs[i].exp_addr));
      resp = 4'd2;
      tick();
      resp  = 4'd0;
      mtag  = 4'd2;
      mdata = vecs[i].data;
      tick();
      mtag = 4'd0;
      #1;
      check($sformatf("vec%0d_slot0", i), 256'(pkt[0]), 256'(vecs[i].exp_s0));
      check($sformatf("vec%0d_slot1", i), 256'(pkt[1]), 256'(vecs[i].exp_s1));
      check($sformatf("vec%0d_next_addr", i), 256'(addr), 256'(vecs[i].exp_next));
    end

    // Credit exhaustion, then a single pop releases exactly one request
    do_reset();
    auto_serve(80, 100, acc, push);
    #1;
    check("exh_accepts", 256'(acc), 256'(16));
    check("exh_pushes", 256'(push), 256'(16));
    check("exh_credits", 256'(credits), 256'(0));
    check("exh_state", 256'(fsm_state), 256'(ST_IDLE));
    check("exh_cmd", 256'(cmd), 256'(BUS_NONE));
    pair_pop = 1'b1;
    tick();
    pair_pop = 1'b0;
    #1;
    check("exh_pop_credits", 256'(credits), 256'(1));
    auto_serve(20, 100, acc, push);
    #1;
    check("exh_one_more", 256'(acc), 256'(1));
    check("exh_final_credits", 256'(credits), 256'(0));

    // Pop and accept together at 8 credits; then the same with squash during a push
    do_reset();
    auto_serve(40, 8, acc, push);
    #1;
    check("sim_credits8", 256'(credits), 256'(8));
    check("sim_cmd", 256'(cmd), 256'(BUS_LOAD));
    resp     = 4'd4;
    pair_pop = 1'b1;
    tick();
    resp     = 4'd0;
    pair_pop = 1'b0;
    #1;
    check("sim_pop_accept", 256'(credits), 256'(8));
    mtag = 4'd4;
    tick();
    mtag      = 4'd0;
    resp      = 4'd5;
    pair_pop  = 1'b1;
    squash    = 1'b1;
    squash_pc = 32'h0000_0040;
    #1;
    check("sim_squash_cmd", 256'(cmd), 256'(BUS_NONE));
    check("sim_squash_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
    tick();
    idle_inputs();
    #1;
    check("sim_squash_credits", 256'(credits), 256'(16));
    check("sim_squash_addr", 256'(addr), 256'(32'h40));

    // Squash while waiting, then squash with data returning in the same cycle
    do_reset();
    tick();
    resp = 4'd5;
    tick();
    resp      = 4'd0;
    squash    = 1'b1;
    squash_pc = 32'h0000_0200;
    #1;
    check("sqw_cmd", 256'(cmd), 256'(BUS_NONE));
    tick();
    squash = 1'b0;
    #1;
    check("sqw_credits", 256'(credits), 256'(16));
    check("sqw_state", 256'(fsm_state), 256'(ST_WAIT));
    mtag  = 4'd5;
    mdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    mtag = 4'd0;
    #1;
    check("sqw_no_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
    check("sqw_addr", 256'(addr), 256'(32'h200));
    resp = 4'd6;
    tick();
    resp      = 4'd0;
    mtag      = 4'd6;
    squash    = 1'b1;
    squash_pc = 32'h0000_0300;
    tick();
    mtag   = 4'd0;
    squash = 1'b0;
    #1;
    check("sqr_no_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
    check("sqr_state", 256'(fsm_state), 256'(ST_REQ));
    check("sqr_addr", 256'(addr), 256'(32'h300));

    // Reset with tag 7 outstanding; the stale return must be ignored
    resp = 4'd7;
    tick();
    resp  = 4'd0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mtag  = 4'd7;
    #1;
    check("rmid_idle", 256'(fsm_state), 256'(ST_IDLE));
    check("rmid_cmd", 256'(cmd), 256'(BUS_NONE));
    tick();
    check("rmid_req", 256'(fsm_state), 256'(ST_REQ));
    check("rmid_addr", 256'(addr), 256'(0));
    check("rmid_no_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
    tick();
    mtag = 4'd0;
    check("rmid_no_push2", 256'({pkt[0][96], pkt[1][96]}), 256'(0));

    // Randomized run against the transaction-level model
    begin
      logic [31:0] m_pc, sq_pc, rnd;
      logic [63:0] out_data;
      logic [3:0]  out_tag, next_tag;
      logic [193:0] e;
      int  m_cred, out_wait, r_acc, r_push;
      bit  outst, drop, sq, pop, ret, accd;

      do_reset();
      m_pc     = 32'h0;
      m_cred   = CREDITS;
      outst    = 1'b0;
      drop     = 1'b0;
      out_tag  = 4'd0;
      out_data = 64'd0;
      out_wait = 0;
      next_tag = 4'd1;
      r_acc    = 0;
      r_push   = 0;
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
        sq    = ($urandom_range(0, 39) == 0);
        rnd   = $urandom();
        sq_pc = {rnd[31:2], 2'b00};
        pop   = (m_cred < CREDITS) && ($urandom_range(0, 2) == 0);
        ret   = outst && (out_wait == 0);
        squash    = sq;
        squash_pc = sq_pc;
        pair_pop  = pop;
        resp      = (!outst && $urandom_range(0, 3) != 0) ? next_tag : 4'd0;
        if (ret) begin
          mtag  = out_tag;
          mdata = out_data;
        end else if (outst && $urandom_range(0, 3) == 0) begin
          mtag  = out_tag ^ 4'h8;
          mdata = {$urandom(), $urandom()};
        end else begin
          mtag  = 4'd0;
          mdata = 64'd0;
        end
        #1;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (sq) begin
            check("rnd_squashed_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
          end else begin
            check("rnd_push", 256'({pkt[0], pkt[1]}), 256'(e));
            r_push++;
          end
        end else begin
          check("rnd_no_push", 256'({pkt[0][96], pkt[1][96]}), 256'(0));
        end
        check("rnd_credits", 256'(credits), 256'(m_cred));
        if (sq || outst || m_cred == 0) check("rnd_cmd_none", 256'(cmd), 256'(BUS_NONE));
        accd = (cmd == BUS_LOAD) && (resp != 4'd0);
        if (accd) check("rnd_addr", 256'(addr), 256'({m_pc[31:3], 3'b000}));

        if (sq) begin
          m_pc   = sq_pc;
          m_cred = CREDITS;
          if (outst && !ret) begin
            drop = 1'b1;
          end else begin
            outst = 1'b0;
            drop  = 1'b0;
          end
        end else begin
          if (accd) begin
            m_cred--;
            outst    = 1'b1;
            out_tag  = resp;
            out_data = {$urandom(), $urandom()};
            out_wait = $urandom_range(0, 3);
            next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            r_acc++;
          end
          if (pop) m_cred++;
          if (ret) begin
            outst = 1'b0;
            if (!drop) begin
              exp_q.push_back(pair_of(m_pc, mdata));
              m_pc = {m_pc[31:3], 3'b000} + 32'd8;
            end
            drop = 1'b0;
          end else if (outst && !accd) begin
            out_wait--;
          end
        end
        tick();
      end
      idle_inputs();
      check("rnd_accept_activity", 256'(r_acc >= 100), 256'(1));
      check("rnd_push_activity", 256'(r_push >= 50), 256'(1));
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
